// File: rtl/mt_ctrl_fsm_pkg.sv
// Shared constants and decode types for the multi-cycle CPU control sequencer.
package mt_ctrl_fsm_pkg;

  localparam int unsigned ST_W    = 5;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned OPC_W   = 6;

  localparam logic [ST_W-1:0] S_IDLE   = 5'd0;
  localparam logic [ST_W-1:0] S_IF     = 5'd1;
  localparam logic [ST_W-1:0] S_ID     = 5'd2;
  localparam logic [ST_W-1:0] S_EX_R   = 5'd3;
  localparam logic [ST_W-1:0] S_WB_R   = 5'd4;
  localparam logic [ST_W-1:0] S_EX_I   = 5'd5;
  localparam logic [ST_W-1:0] S_WB_I   = 5'd6;
  localparam logic [ST_W-1:0] S_EX_MA  = 5'd7;
  localparam logic [ST_W-1:0] S_MEM_RD = 5'd8;
  localparam logic [ST_W-1:0] S_WB_MEM = 5'd9;
  localparam logic [ST_W-1:0] S_MEM_WR = 5'd10;
  localparam logic [ST_W-1:0] S_BRANCH = 5'd11;
  localparam logic [ST_W-1:0] S_JUMP   = 5'd12;
  localparam logic [ST_W-1:0] S_ERR    = 5'd13;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPC_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPC_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPC_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPC_W-1:0] OP_SLTI  = 6'b001010;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_SUB   = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_AND   = 3'b011;
  localparam logic [ALUOP_W-1:0] ALU_OR    = 3'b100;
  localparam logic [ALUOP_W-1:0] ALU_SLT   = 3'b101;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_SEXT  = 2'b10;
  localparam logic [1:0] SRCB_SHIFT = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [2:0] {
    CLS_R, CLS_LD, CLS_ST, CLS_BEQ, CLS_BNE, CLS_J, CLS_I, CLS_ILL
  } op_class_e;

  typedef struct packed {
    op_class_e            cls;
    logic                 imm_zext;
    logic [ALUOP_W-1:0]   alu_op;
  } op_dec_t;

endpackage

// File: rtl/mt_op_decode.sv
// Opcode classifier: instruction class plus immediate-extension and ALU op for I-type ALU instructions.
module mt_op_decode
  import mt_ctrl_fsm_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output op_dec_t          dec
);

  always_comb begin
    dec.cls      = CLS_ILL;
    dec.imm_zext = 1'b0;
    dec.alu_op   = ALU_ADD;
    case (opcode)
      OP_RTYPE: dec.cls = CLS_R;
      OP_LW:    dec.cls = CLS_LD;
      OP_SW:    dec.cls = CLS_ST;
      OP_BEQ:   dec.cls = CLS_BEQ;
      OP_BNE:   dec.cls = CLS_BNE;
      OP_J:     dec.cls = CLS_J;
      OP_ADDI:  dec.cls = CLS_I;
      OP_ANDI: begin
        dec.cls      = CLS_I;
        dec.imm_zext = 1'b1;
        dec.alu_op   = ALU_AND;
      end
      OP_ORI: begin
        dec.cls      = CLS_I;
        dec.imm_zext = 1'b1;
        dec.alu_op   = ALU_OR;
      end
      OP_SLTI: begin
        dec.cls    = CLS_I;
        dec.alu_op = ALU_SLT;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mt_ctrl_fsm.sv
// Multi-cycle CPU control sequencer: IF/ID/EX/MEM/WB FSM with memory stalls,
// run/single-step control and a sticky illegal-opcode halt.
module mt_ctrl_fsm
  import mt_ctrl_fsm_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               zero,
  input  logic               mem_ready,
  input  logic               run,
  input  logic               step,
  output logic               pc_write,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               imm_zext,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_source,
  output logic               instr_done,
  output logic               err,
  output logic [ST_W-1:0]    state_o
);

  logic [ST_W-1:0] state;
  logic [ST_W-1:0] state_nx;
  logic [ST_W-1:0] done_st;
  logic            err_q;
  op_dec_t         dec;

  mt_op_decode u_dec (
    .opcode (opcode),
    .dec    (dec)
  );

  // Where a finished instruction goes: keep fetching in run mode, otherwise park.
  assign done_st = run ? S_IF : S_IDLE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Sticky flag aligned with entry into the halt state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (state_nx == S_ERR) begin
      err_q <= 1'b1;
    end
  end

  always_comb begin
    state_nx   = state;
    pc_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    imm_zext   = 1'b0;
    alu_op     = ALU_ADD;
    pc_source  = PCSRC_ALU;
    instr_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (run || step) state_nx = S_IF;
      end
      S_IF: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_4;
        pc_source = PCSRC_ALU;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_nx = S_ID;
      end
      S_ID: begin
        alu_src_b = SRCB_SHIFT;
        case (dec.cls)
          CLS_R:            state_nx = S_EX_R;
          CLS_LD, CLS_ST:   state_nx = S_EX_MA;
          CLS_BEQ, CLS_BNE: state_nx = S_BRANCH;
          CLS_J:            state_nx = S_JUMP;
          CLS_I:            state_nx = S_EX_I;
          default:          state_nx = S_ERR;
        endcase
      end
      S_EX_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_nx  = S_WB_R;
      end
      S_WB_R: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_nx   = done_st;
      end
      S_EX_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_SEXT;
        imm_zext  = dec.imm_zext;
        alu_op    = dec.alu_op;
        state_nx  = S_WB_I;
      end
      S_WB_I: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_nx   = done_st;
      end
      S_EX_MA: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_SEXT;
        state_nx  = (dec.cls == CLS_LD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_nx = S_WB_MEM;
      end
      S_WB_MEM: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_nx   = done_st;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_nx   = done_st;
        end
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_source  = PCSRC_ALUOUT;
        pc_write   = (dec.cls == CLS_BNE) ? ~zero : zero;
        instr_done = 1'b1;
        state_nx   = done_st;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
        state_nx   = done_st;
      end
      S_ERR: state_nx = S_ERR;
      default: state_nx = S_IDLE;
    endcase
  end

  assign err     = err_q;
  assign state_o = state;

endmodule

// File: tb/tb_mt_ctrl_fsm.sv
// Self-checking bench for mt_ctrl_fsm: vector table, stall/step/halt sequences and a random instruction stream.
module tb_mt_ctrl_fsm;

  localparam logic [4:0] S_IDLE = 5'd0, S_IF = 5'd1, S_ID = 5'd2, S_EXR = 5'd3, S_WBR = 5'd4,
                         S_EXI = 5'd5, S_WBI = 5'd6, S_EXMA = 5'd7, S_MRD = 5'd8, S_WBM = 5'd9,
                         S_MWR = 5'd10, S_BR = 5'd11, S_JMP = 5'd12, S_ERR = 5'd13;
  localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b100011, O_SW = 6'b101011, O_BEQ = 6'b000100,
                         O_BNE = 6'b000101, O_J = 6'b000010, O_ADDI = 6'b001000, O_ANDI = 6'b001100,
                         O_ORI = 6'b001101, O_SLTI = 6'b001010;

  logic       clk, rst, zero, mem_ready, run, step;
  logic [5:0] opcode;
  logic       pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, imm_zext, instr_done, err;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [4:0] state_o;

  mt_ctrl_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready), .run(run), .step(step),
    .pc_write(pc_write), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_zext(imm_zext), .alu_op(alu_op),
    .pc_source(pc_source), .instr_done(instr_done), .err(err), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [17:0] outs;
  logic [8:0]  ctl;
  assign outs = {pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                 alu_src_a, alu_src_b, imm_zext, alu_op, pc_source, instr_done};
  assign ctl  = {alu_src_a, alu_src_b, imm_zext, alu_op, pc_source};

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Sample one cycle's state and completion pulse.
  task automatic see(input string name, input logic [4:0] exp_st, input logic exp_done);
    #1;
    chk({name, "_state"}, int'(state_o), int'(exp_st));
    chk({name, "_done"}, int'(instr_done), int'(exp_done));
  endtask

  typedef struct {
    logic [5:0]      opc;
    logic            z;
    int              len;
    logic [0:4][4:0] st;
    int              n_pcw;
    int              n_regw;
    int              n_memw;
    logic [8:0]      exctl;
  } vec_t;

  function automatic vec_t mk(input logic [5:0] o, input logic z, input int len, input logic [24:0] st,
                              input int p, input int r, input int w, input logic [8:0] x);
    vec_t v;
    v.opc = o; v.z = z; v.len = len; v.st = st;
    v.n_pcw = p; v.n_regw = r; v.n_memw = w; v.exctl = x;
    return v;
  endfunction

  vec_t tbl[12];
  logic [5:0] ops[10];
  logic [4:0] lw_st[10];
  logic       lw_mr[10];

  initial begin
    int npcw, nrw, nmw, nirw;
    rst = 1'b0; run = 1'b0; step = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = 6'd0;

    tbl[0]  = mk(O_R,    0, 4, {S_IF, S_ID, S_EXR,  S_WBR, 5'd0}, 1, 1, 0, 9'b1_00_0_010_00);
    tbl[1]  = mk(O_ADDI, 0, 4, {S_IF, S_ID, S_EXI,  S_WBI, 5'd0}, 1, 1, 0, 9'b1_10_0_000_00);
    tbl[2]  = mk(O_ANDI, 0, 4, {S_IF, S_ID, S_EXI,  S_WBI, 5'd0}, 1, 1, 0, 9'b1_10_1_011_00);
    tbl[3]  = mk(O_ORI,  0, 4, {S_IF, S_ID, S_EXI,  S_WBI, 5'd0}, 1, 1, 0, 9'b1_10_1_100_00);
    tbl[4]  = mk(O_SLTI, 0, 4, {S_IF, S_ID, S_EXI,  S_WBI, 5'd0}, 1, 1, 0, 9'b1_10_0_101_00);
    tbl[5]  = mk(O_LW,   0, 5, {S_IF, S_ID, S_EXMA, S_MRD, S_WBM}, 1, 1, 0, 9'b1_10_0_000_00);
    tbl[6]  = mk(O_SW,   0, 4, {S_IF, S_ID, S_EXMA, S_MWR, 5'd0}, 1, 0, 1, 9'b1_10_0_000_00);
    tbl[7]  = mk(O_BEQ,  1, 3, {S_IF, S_ID, S_BR, 10'd0}, 2, 0, 0, 9'b1_00_0_001_01);
    tbl[8]  = mk(O_BEQ,  0, 3, {S_IF, S_ID, S_BR, 10'd0}, 1, 0, 0, 9'b1_00_0_001_01);
    tbl[9]  = mk(O_BNE,  1, 3, {S_IF, S_ID, S_BR, 10'd0}, 1, 0, 0, 9'b1_00_0_001_01);
    tbl[10] = mk(O_BNE,  0, 3, {S_IF, S_ID, S_BR, 10'd0}, 2, 0, 0, 9'b1_00_0_001_01);
    tbl[11] = mk(O_J,    0, 3, {S_IF, S_ID, S_JMP, 10'd0}, 2, 0, 0, 9'b0_00_0_000_10);
    ops = '{O_R, O_LW, O_SW, O_BEQ, O_BNE, O_J, O_ADDI, O_ANDI, O_ORI, O_SLTI};
    lw_st = '{S_IF, S_IF, S_IF, S_IF, S_ID, S_EXMA, S_MRD, S_MRD, S_MRD, S_WBM};
    lw_mr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset, then idle in step mode with no step.
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_state", int'(state_o), int'(S_IDLE));
    chk("rst_outs", int'(outs), 0);
    chk("rst_err", int'(err), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("idle%0d_state", c), int'(state_o), int'(S_IDLE));
      chk($sformatf("idle%0d_outs", c), int'(outs), 0);
      chk($sformatf("idle%0d_err", c), int'(err), 0);
      @(negedge clk);
    end

    // Vector table, free-running, memory always ready.
    run = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 12; t++) begin
      opcode = tbl[t].opc; zero = tbl[t].z; mem_ready = 1'b1;
      npcw = 0; nrw = 0; nmw = 0;
      for (int c = 0; c < tbl[t].len; c++) begin
        see($sformatf("tbl%0d_c%0d", t, c), tbl[t].st[c], 1'(c == tbl[t].len - 1));
        if (c == 0) chk($sformatf("tbl%0d_if_ctl", t), int'(ctl), int'(9'b0_01_0_000_00));
        if (c == 1) chk($sformatf("tbl%0d_id_ctl", t), int'(ctl), int'(9'b0_11_0_000_00));
        if (c == 2) chk($sformatf("tbl%0d_ex_ctl", t), int'(ctl), int'(tbl[t].exctl));
        npcw += int'(pc_write); nrw += int'(reg_write); nmw += int'(mem_write);
        @(negedge clk);
      end
      chk($sformatf("tbl%0d_pcw", t), npcw, tbl[t].n_pcw);
      chk($sformatf("tbl%0d_regw", t), nrw, tbl[t].n_regw);
      chk($sformatf("tbl%0d_memw", t), nmw, tbl[t].n_memw);
    end

    // lw with fetch and data stalls: 10 cycles total.
    opcode = O_LW; npcw = 0; nirw = 0;
    for (int c = 0; c < 10; c++) begin
      mem_ready = lw_mr[c];
      see($sformatf("lwst_c%0d", c), lw_st[c], 1'(c == 9));
      npcw += int'(pc_write); nirw += int'(ir_write);
      @(negedge clk);
    end
    chk("lwst_pcw", npcw, 1);
    chk("lwst_irw", nirw, 1);

    // Random instruction stream against an instruction-level model.
    for (int n = 0; n < 40; n++) begin
      logic [5:0] o;
      logic z, is_r, is_i, is_lw, is_sw, is_br, is_j, taken;
      int k, m, len, nd, dat, nmr, rdst, m2r;
      o = ops[$urandom_range(0, 9)];
      z = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 3);
      m = $urandom_range(0, 3);
      is_r = (o == O_R); is_lw = (o == O_LW); is_sw = (o == O_SW); is_j = (o == O_J);
      is_br = (o == O_BEQ) || (o == O_BNE);
      is_i = (o == O_ADDI) || (o == O_ANDI) || (o == O_ORI) || (o == O_SLTI);
      taken = ((o == O_BEQ) && z) || ((o == O_BNE) && !z) || is_j;
      len = (is_lw ? 5 : (is_br || is_j) ? 3 : 4) + k + ((is_lw || is_sw) ? m : 0);
      opcode = o; zero = z;
      npcw = 0; nrw = 0; nmw = 0; nirw = 0; nd = 0; dat = -1; nmr = 0; rdst = -1; m2r = -1;
      for (int c = 0; c < len; c++) begin
        if (c < k) mem_ready = 1'b0;
        else if (c == k) mem_ready = 1'b1;
        else if ((is_lw || is_sw) && c >= k + 3 && c < k + 3 + m) mem_ready = 1'b0;
        else if ((is_lw || is_sw) && c == k + 3 + m) mem_ready = 1'b1;
        else mem_ready = 1'($urandom_range(0, 1));
        #1;
        npcw += int'(pc_write); nrw += int'(reg_write); nmw += int'(mem_write);
        nirw += int'(ir_write); nmr += int'(mem_read && i_or_d);
        if (instr_done) begin nd++; dat = c; end
        if (reg_write) begin rdst = int'(reg_dst); m2r = int'(mem_to_reg); end
        @(negedge clk);
      end
      chk($sformatf("rnd%0d_op%0d_pcw", n, o), npcw, 1 + int'(taken));
      chk($sformatf("rnd%0d_op%0d_irw", n, o), nirw, 1);
      chk($sformatf("rnd%0d_op%0d_regw", n, o), nrw, int'(is_r || is_i || is_lw));
      chk($sformatf("rnd%0d_op%0d_memw", n, o), nmw, is_sw ? m + 1 : 0);
      chk($sformatf("rnd%0d_op%0d_memrd", n, o), nmr, is_lw ? m + 1 : 0);
      chk($sformatf("rnd%0d_op%0d_ndone", n, o), nd, 1);
      chk($sformatf("rnd%0d_op%0d_doneat", n, o), dat, len - 1);
      if (is_r || is_i || is_lw) begin
        chk($sformatf("rnd%0d_op%0d_regdst", n, o), rdst, int'(is_r));
        chk($sformatf("rnd%0d_op%0d_memtoreg", n, o), m2r, int'(is_lw));
      end
    end

    // Reset during a fetch stall aborts immediately.
    mem_ready = 1'b0; run = 1'b0;
    @(negedge clk); @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("stallrst_state", int'(state_o), int'(S_IDLE));
    chk("stallrst_outs", int'(outs), 0);
    @(negedge clk);
    rst = 1'b1;

    // Single-step: sw, stray step mid-instruction ignored, then one R-type.
    opcode = O_SW; mem_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin see($sformatf("park%0d", c), S_IDLE, 1'b0); @(negedge clk); end
    step = 1'b1;
    see("step1_pre", S_IDLE, 1'b0);
    @(negedge clk);
    begin
      logic [4:0] sq[7];
      sq = '{S_IF, S_ID, S_EXMA, S_MWR, S_IDLE, S_IDLE, S_IDLE};
      for (int c = 0; c < 7; c++) begin
        step = 1'(c == 1);
        see($sformatf("step1_c%0d", c), sq[c], 1'(c == 3));
        @(negedge clk);
      end
    end
    opcode = O_R; step = 1'b1;
    see("step2_pre", S_IDLE, 1'b0);
    @(negedge clk);
    step = 1'b0;
    begin
      logic [4:0] sq[5];
      sq = '{S_IF, S_ID, S_EXR, S_WBR, S_IDLE};
      for (int c = 0; c < 5; c++) begin
        see($sformatf("step2_c%0d", c), sq[c], 1'(c == 3));
        @(negedge clk);
      end
      // Free-run dropped mid-instruction: finish, then park.
      run = 1'b1;
      see("rundrop_pre", S_IDLE, 1'b0);
      @(negedge clk);
      for (int c = 0; c < 5; c++) begin
        run = 1'(c == 0);
        see($sformatf("rundrop_c%0d", c), sq[c], 1'(c == 3));
        @(negedge clk);
      end
    end

    // Illegal opcode: sticky halt until reset.
    opcode = 6'b111111; run = 1'b1;
    see("ill_pre", S_IDLE, 1'b0);
    @(negedge clk);
    see("ill_if", S_IF, 1'b0);
    @(negedge clk);
    see("ill_id", S_ID, 1'b0);
    @(negedge clk);
    #1;
    chk("ill_state", int'(state_o), int'(S_ERR));
    chk("ill_err", int'(err), 1);
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      mem_ready = 1'($urandom_range(0, 1));
      run = 1'($urandom_range(0, 1));
      step = 1'($urandom_range(0, 1));
      opcode = ops[$urandom_range(0, 9)];
      #1;
      chk($sformatf("halt%0d_state", c), int'(state_o), int'(S_ERR));
      chk($sformatf("halt%0d_outs", c), int'(outs), 0);
      chk($sformatf("halt%0d_err", c), int'(err), 1);
      @(negedge clk);
    end
    #2;
    rst = 1'b0;
    #1;
    chk("errrst_state", int'(state_o), int'(S_IDLE));
    chk("errrst_err", int'(err), 0);
    chk("errrst_outs", int'(outs), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
